serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract sequencer. It time-multiplexes a single instance of the team's one-bit `fulladder` cell (ports a, b, c_in, sum, c_out) over WIDTH-bit operands, processing one bit per clock from the LSB. It holds the inter-bit carry in a register and presents a start/busy/done handshake to the surrounding datapath. It is the area-minimal alternative to a WIDTH-bit ripple adder, for use where latency is acceptable.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
op_sub  input  1  0 = add (a + b + cin), 1 = subtract (a - b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
cin  input  1  carry-in for add; ignored when op_sub=1
busy  output  1  high from the cycle after start is accepted until the DONE cycle ends
done  output  1  single-cycle pulse; result valid
sum  output  WIDTH  result; updated only when entering DONE
cout  output  1  final carry-out (for subtract: 1 = no borrow)
ovf  output  1  signed overflow = (carry into MSB) XOR cout

Behaviour:
- Reset: on a clk edge with rst_n=0, the block enters IDLE and clears the following: busy=0, done=0, sum=0, cout=0, ovf=0, bit counter=0, carry=0, shift registers=0. Reset wins over all other inputs.
- States: IDLE, RUN, DONE (2-bit encoding, free choice).
- IDLE -> RUN: on an edge with start=1, the block captures the following:
  - a into the A shift register.
  - b into the B shift register when op_sub=0, or ~b when op_sub=1.
  - carry <= cin when op_sub=0, or 1 when op_sub=1.
  - counter <= 0.
  - busy goes high at that edge.
- RUN:
  - Each edge applies A[0], B[0] and carry to the fulladder.
  - The fulladder sum shifts into the MSB of the result shift register; A and B shift right by one.
  - carry <= c_out; counter increments.
  - On the edge where counter == WIDTH-1 (the last bit), the block also records carry-before-update as msb_cin and transitions to DONE.
- RUN -> DONE edge: the block loads the output registers:
  - sum <= completed result.
  - cout <= final c_out.
  - ovf <= msb_cin ^ final c_out.
  - done <= 1.
- DONE: lasts exactly one cycle. done=1, busy=1. At the next edge: done=0, busy=0, state -> IDLE. start is ignored in DONE.
- Latency: if start is sampled at edge 0, bits are processed at edges 1..WIDTH and done is high between edges WIDTH and WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles when start is held high continuously.
- Output hold: sum, cout and ovf keep their last values through IDLE and through the next RUN. They change only at the next RUN->DONE edge or on reset.
- start, a, b, op_sub and cin are don't-care while busy=1. Changes to them must not affect the operation in flight.
- Reset mid-RUN: the operation is aborted. No done pulse is produced, outputs are cleared to 0, and a start one edge after rst_n rises is accepted normally.
- Arithmetic is modulo 2^WIDTH. There are no X or undefined outputs after the first reset.

Test Plan:
1. WIDTH=8, add, a=0x3C, b=0x0F, cin=0, start at edge 0 -> done high only between edges 8 and 9; sum=0x4B, cout=0, ovf=0; busy high edges 0..9.
2. Add, a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0. Then add a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
3. Subtract, a=0x05, b=0x07 (cin=1 driven, must be ignored) -> sum=0xFE, cout=0, ovf=0. Subtract a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
4. Start op a=0x10, b=0x20, then pulse start with a=0xAA, b=0x55 at edge 3 -> second request ignored; single done at edge 8 with sum=0x30; busy stays continuously high.
5. start held high for 30 cycles with fixed operands -> done pulses exactly every 10 cycles (WIDTH+2); sum/cout/ovf stable between pulses.
6. Start op, drive rst_n=0 at edge 4 -> busy=0 and sum=0 after that edge, no done pulse. Release reset and start a=0x01, b=0x01 -> done after 8 edges with sum=0x02.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell reused over WIDTH clocks, LSB first,
// with a start/busy/done handshake and registered sum/cout/ovf results.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;

    logic               fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic [WIDTH-1:0]   res_next;

    // The single shared one-bit full adder, fed from the operand LSBs and the carry register
    always_comb begin
        fa_a    = a_sh_q[0];
        fa_b    = b_sh_q[0];
        fa_cin  = carry_q;
        fa_sum  = fa_a ^ fa_b ^ fa_cin;
        fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    end

    assign res_next = {fa_sum, res_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + 1: invert B and force the initial carry
                    a_sh_d  = a;
                    b_sh_d  = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_next;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB
                    sum_d   = res_next;
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random operations scored
// against an integer-arithmetic reference model, with cycle-exact handshake checks.
module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] hold_sum;
    logic             hold_cout;
    logic             hold_ovf;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the sampled operands
    function automatic void model(input logic [7:0] ta, input logic [7:0] tb_v,
                                  input logic top, input logic tcin,
                                  output logic [7:0] es, output logic ec, output logic eo);
        int sa, sb, ua, ub, ci, u, sv;
        sa = $signed(ta);
        sb = $signed(tb_v);
        ua = int'(ta);
        ub = int'(tb_v);
        ci = int'(tcin);
        if (!top) begin
            u  = ua + ub + ci;
            sv = sa + sb + ci;
            ec = (u > 255);
        end else begin
            u  = ua - ub;
            sv = sa - sb;
            ec = (ua >= ub);
        end
        es = 8'(u);
        eo = (sv > 127) || (sv < -128);
    endfunction

    task automatic drive_noise();
        start  = 1'($urandom);
        a      = 8'($urandom);
        b      = 8'($urandom);
        op_sub = 1'($urandom);
        cin    = 1'($urandom);
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic top,
                         input logic tcin, input bit hammer);
        logic [7:0] es;
        logic       ec, eo;
        model(ta, tb_v, top, tcin, es, ec, eo);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; a = ta; b = tb_v; op_sub = top; cin = tcin;
        @(posedge clk); #1;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done", 32'(done), 32'd0);
        for (int k = 1; k <= int'(WIDTH); k++) begin
            @(negedge clk);
            if (hammer) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; op_sub = ~top; cin = ~tcin;
            end else begin
                drive_noise();
            end
            @(posedge clk); #1;
            if (k < int'(WIDTH)) begin
                check("run_busy", 32'(busy), 32'd1);
                check("run_done", 32'(done), 32'd0);
                check("run_hold_sum", 32'(sum), 32'(hold_sum));
                check("run_hold_cout", 32'(cout), 32'(hold_cout));
                check("run_hold_ovf", 32'(ovf), 32'(hold_ovf));
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("done_busy", 32'(busy), 32'd1);
                check("sum", 32'(sum), 32'(es));
                check("cout", 32'(cout), 32'(ec));
                check("ovf", 32'(ovf), 32'(eo));
            end
        end
        @(negedge clk);
        if (hammer) start = 1'b1; else drive_noise();
        @(posedge clk); #1;
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_sum", 32'(sum), 32'(es));
        start = 1'b0;
        hold_sum = es; hold_cout = ec; hold_ovf = eo;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'd0);
        check({tag, "_cout"}, 32'(cout), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        logic [7:0] es;
        logic       ec, eo;
        int         last, pulses;

        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        hold_sum = '0; hold_cout = 1'b0; hold_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");

        // Directed arithmetic cases including carry-out, overflow and ignored cin on subtract
        do_op(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
        // Requests while busy must be ignored
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);

        // start held continuously: one result every WIDTH+2 cycles
        model(8'h3C, 8'h0F, 1'b0, 1'b0, es, ec, eo);
        @(negedge clk);
        start = 1'b1; a = 8'h3C; b = 8'h0F; op_sub = 1'b0; cin = 1'b0;
        last = -1; pulses = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                if (pulses > 0) check("period", 32'(cyc - last), 32'(WIDTH + 2));
                else            check("first_done", 32'(cyc), 32'(WIDTH));
                check("stream_sum", 32'(sum), 32'(es));
                last = cyc;
                pulses++;
            end else if (pulses > 0) begin
                check("stream_hold", 32'({ovf, cout, sum}), 32'({eo, ec, es}));
            end
        end
        start = 1'b0;
        check("pulse_count", 32'(pulses), 32'd4);
        hold_sum = es; hold_cout = ec; hold_ovf = eo;
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        check("stream_idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of an operation aborts it
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h44; op_sub = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("pre_abort_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_cleared("abort");
        hold_sum = '0; hold_cout = 1'b0; hold_ovf = 1'b0;
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

        // Random back-to-back operations with occasional idle gaps
        for (int n = 0; n < 40; n++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                check("idle_done", 32'(done), 32'd0);
                check("idle_sum", 32'(sum), 32'(hold_sum));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
